fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, combinational instruction RAM read and the IF/ID pipeline register.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] pc_debug,
  output logic [31:0] instr_debug,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Loaded from outside (hierarchical preload); there is deliberately no write port.
  logic [31:0] mem [MEM_DEPTH];

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Control semantics: redirect_valid wins over stall and squashes the wrong-path
  // word into a bubble; stall alone freezes PC and IF/ID; otherwise fetch advances.
  assign pc_plus4    = pc + 32'd4;
  assign pc_debug    = pc;
  assign instr_debug = mem[pc[AW+1:2]];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
    end else if (redirect_valid) begin
      pc             <= redirect_target;
      if_id_valid    <= 1'b0;
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
    end else if (!stall) begin
      pc             <= pc_plus4;
      if_id_valid    <= 1'b1;
      if_id_instr    <= instr_debug;
      if_id_pc_plus4 <= pc_plus4;
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_adv;
  logic bubble_ins;
  logic [31:0] fetched_q;
  logic [31:0] bubbles_q;

  assign fetch_adv  = !redirect_valid && !stall;
  assign bubble_ins = redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= 32'h0;
      bubbles_q <= 32'h0;
    end else begin
      if (fetch_adv)  fetched_q <= fetched_q + 32'd1;
      if (bubble_ins) bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage: a reference model pushes expected IF/ID
// contents into exp_q as each cycle is driven; they are popped and checked after the edge.
module tb_fetch_stage;

  localparam int MEM_DEPTH = 256;
`ifdef FETCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] pc_debug;
  logic [31:0] instr_debug;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  fetch_stage #(.MEM_DEPTH(MEM_DEPTH), .RESET_PC(32'h00000000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .pc_debug        (pc_debug),
    .instr_debug     (instr_debug),
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [64:0] exp_q[$];
  logic [31:0] model_mem [MEM_DEPTH];
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [31:0] m_fetched;
  logic [31:0] m_bubbles;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] perf_exp(input logic [31:0] cnt);
    return PERF_EN ? cnt : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_valid   = 1'b0;
    m_instr   = 32'h0;
    m_pc4     = 32'h0;
    m_fetched = 32'h0;
    m_bubbles = 32'h0;
  endtask

  // driver: apply reset for n edges with the given side inputs also asserted
  task automatic do_reset(input int n, input logic st, input logic rv, input logic [31:0] tgt);
    reset = 1'b1; stall = st; redirect_valid = rv; redirect_target = tgt;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    model_reset();
    exp_q.delete();
  endtask

  // driver: one clock of stimulus; the model predicts and the scoreboard checks after the edge
  task automatic step(input logic st, input logic rv, input logic [31:0] tgt);
    logic [64:0] got;
    logic [64:0] exp;
    stall = st; redirect_valid = rv; redirect_target = tgt;
    if (rv) begin
      m_pc = tgt; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_bubbles++;
    end else if (!st) begin
      m_instr = model_mem[m_pc[9:2]];
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fetched++;
    end
    exp_q.push_back({m_valid, m_instr, m_pc4});
    @(posedge clk);
    #1;
    stall = 1'b0; redirect_valid = 1'b0;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 65'd1, 65'd0);
    end else begin
      exp = exp_q.pop_front();
      got = {if_id_valid, if_id_instr, if_id_pc_plus4};
      chk("if_id", got, exp);
    end
    chk("pc_debug", {33'h0, pc_debug}, {33'h0, m_pc});
    chk("instr_debug", {33'h0, instr_debug}, {33'h0, model_mem[m_pc[9:2]]});
    chk("perf_fetched", {33'h0, perf_fetched}, {33'h0, perf_exp(m_fetched)});
    chk("perf_bubbles", {33'h0, perf_bubbles}, {33'h0, perf_exp(m_bubbles)});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    model_reset();

    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = $urandom;
    model_mem[0]  = 32'h20100001;
    model_mem[1]  = 32'h20110002;
    model_mem[2]  = 32'h20120003;
    model_mem[12] = 32'h2012004D;
    for (int i = 0; i < MEM_DEPTH; i++) dut.mem[i] = model_mem[i];

    // reset held two cycles
    do_reset(2, 1'b0, 1'b0, 32'h0);
    chk("rst_pc", {33'h0, pc_debug}, 65'h0);
    chk("rst_valid", {64'h0, if_id_valid}, 65'h0);
    chk("rst_instr", {33'h0, if_id_instr}, 65'h0);
    chk("rst_pc4", {33'h0, if_id_pc_plus4}, 65'h0);
    chk("rst_perf_f", {33'h0, perf_fetched}, 65'h0);
    chk("rst_perf_b", {33'h0, perf_bubbles}, 65'h0);

    // sequential fetch to pc=0x08, stall twice, then resume
    step(1'b0, 1'b0, 32'h0);
    chk("seq1_instr", {33'h0, if_id_instr}, {33'h0, 32'h20100001});
    step(1'b0, 1'b0, 32'h0);
    chk("seq2_pc", {33'h0, pc_debug}, {33'h0, 32'h8});
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("stall_pc", {33'h0, pc_debug}, {33'h0, 32'h8});
    chk("stall_instr", {33'h0, if_id_instr}, {33'h0, 32'h20110002});
    chk("stall_perf", {33'h0, perf_fetched}, {33'h0, perf_exp(32'd2)});
    step(1'b0, 1'b0, 32'h0);
    chk("seq3_pc", {33'h0, pc_debug}, {33'h0, 32'h0C});
    chk("seq3_instr", {33'h0, if_id_instr}, {33'h0, 32'h20120003});
    chk("seq3_pc4", {33'h0, if_id_pc_plus4}, {33'h0, 32'h0C});
    chk("seq3_perf", {33'h0, perf_fetched}, {33'h0, perf_exp(32'd3)});

    // redirect together with stall at pc=0x10
    step(1'b0, 1'b0, 32'h0);
    chk("pre_redir_pc", {33'h0, pc_debug}, {33'h0, 32'h10});
    step(1'b1, 1'b1, 32'h28);
    chk("redir_pc", {33'h0, pc_debug}, {33'h0, 32'h28});
    chk("redir_valid", {64'h0, if_id_valid}, 65'h0);
    chk("redir_instr", {33'h0, if_id_instr}, 65'h0);
    chk("redir_bubbles", {33'h0, perf_bubbles}, {33'h0, perf_exp(32'd1)});

    // back-to-back redirects, including a misaligned target
    step(1'b0, 1'b1, 32'h44);
    step(1'b0, 1'b1, 32'h53);
    chk("b2b_pc", {33'h0, pc_debug}, {33'h0, 32'h53});
    chk("b2b_bubbles", {33'h0, perf_bubbles}, {33'h0, perf_exp(32'd3)});
    step(1'b0, 1'b0, 32'h0);
    chk("misal_pc4", {33'h0, if_id_pc_plus4}, {33'h0, 32'h57});

    // randomized mix of advance, stall and redirect
    for (int i = 0; i < 60; i++) begin
      logic st;
      logic rv;
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 5) == 0);
      step(st, rv, $urandom_range(0, 32'h3FF));
    end

    // high PC bits ignored for indexing
    step(1'b0, 1'b1, 32'h00400030);
    chk("wrap_pc", {33'h0, pc_debug}, {33'h0, 32'h00400030});
    chk("wrap_instr", {33'h0, instr_debug}, {33'h0, 32'h2012004D});
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_pc4", {33'h0, if_id_pc_plus4}, {33'h0, 32'h00400034});
    chk("wrap_ifid", {33'h0, if_id_instr}, {33'h0, 32'h2012004D});

    // reset overrides concurrent redirect and stall
    do_reset(1, 1'b1, 1'b1, 32'h40);
    chk("mrst_pc", {33'h0, pc_debug}, 65'h0);
    chk("mrst_valid", {64'h0, if_id_valid}, 65'h0);
    chk("mrst_perf_f", {33'h0, perf_fetched}, 65'h0);
    chk("mrst_perf_b", {33'h0, perf_bubbles}, 65'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("mrst_first", {33'h0, if_id_instr}, {33'h0, 32'h20100001});
    chk("mem_kept", {33'h0, dut.mem[12]}, {33'h0, 32'h2012004D});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
